spi_rx_frame_ctrl: RTL and testbench
====================================

Name: spi_rx_frame_ctrl

Overview:
Sequences the SPI slave receive path. Synchronises raw sck/cs_n/mosi pins into the clk domain, detects sck rising edges, counts bits, and assembles bytes. Completed bytes are presented on a valid/ack holding register with nibble split for the display logic. Multi-byte frames, overrun and mid-byte chip-select aborts are flagged.

Parameters:
DATA_W, 8, bits per word (>=2)
SYNC_STAGES, 2, flip-flop stages on each pin synchroniser (>=2)

Ports:
clk  in  1  system clock; must be >=4x sck frequency
rst  in  1  asynchronous active-low reset
sck  in  1  raw SPI clock pin; mode 0, sample on rising edge
cs_n  in  1  raw chip select pin, active-low
mosi  in  1  raw serial data pin, MSB first
byte_ack  in  1  consumer acknowledges byte_data
byte_data  out  DATA_W  last completed word
data1  out  4  byte_data[3:0]
data2  out  4  byte_data[7:4]
byte_valid  out  1  byte_data holds an unconsumed word
busy  out  1  frame in progress (state ACTIVE)
overrun  out  1  sticky: word completed while previous unconsumed
abort_err  out  1  one-cycle pulse: cs_n rose mid-word
byte_count  out  8  words completed in current frame, saturating

Behaviour:
- Reset (rst=0, async): all outputs 0; synchronisers, shift register and bit counter cleared; state IDLE. Reset mid-frame drops the partial word; after release the block waits for a fresh cs_n falling edge.
- Sync: sck, cs_n and mosi each pass through SYNC_STAGES flops; mosi uses the same depth, so it stays aligned with sck. Rising edge = synced sck 1 now, 0 previous cycle. cs_n edges are detected the same way.
- FSM IDLE: busy=0. Synced cs_n falling edge -> ACTIVE; bit_cnt=0, byte_count=0, overrun=0. sck edges in IDLE are ignored.
- FSM ACTIVE: busy=1.
  - Each sck rising edge: shift_reg <= {shift_reg[DATA_W-2:0], mosi_s}; bit_cnt++.
  - On the edge where bit_cnt==DATA_W-1: word complete, bit_cnt wraps to 0, state stays ACTIVE (next word of the same frame).
  - Synced cs_n rising edge -> IDLE. If bit_cnt!=0, abort_err pulses for 1 cycle and the partial word is discarded. byte_data and byte_valid are unaffected.
- Completion latency: the completed word is on byte_data and byte_valid=1 in the cycle after the detected final sck edge.
- Holding register handshake:
  - byte_valid stays 1 until a cycle with byte_ack=1; it clears the following cycle.
  - byte_ack while byte_valid=0 is ignored.
- Word completes while byte_valid=1 and byte_ack=0: new word dropped, old word retained, overrun<=1. overrun stays set until the next frame start or reset.
- Word completes in the same cycle as byte_ack with byte_valid=1: new word loaded, byte_valid stays 1, no overrun.
- byte_count increments on every completed word, including dropped ones, and saturates at 255.
- data1/data2 are pure slices of byte_data. For DATA_W<8 the unused upper bits read 0; for DATA_W>8 only bits [7:0] are sliced.
- cs_n falling and rising edge detected in the same cycle is impossible after synchronisation. An sck edge coincident with cs_n rising is processed before the abort check.

Test Plan:
- Reset + single word: cs_n low, shift 0xA5 MSB first, ack 3 cycles after valid -> byte_data=0xA5, data1=0x5, data2=0xA, byte_valid high until the cycle after ack, byte_count=1, overrun=0.
- Back-to-back words, consumer acks each promptly: frame 0x3C,0xF0 -> two valid assertions with 0x3C then 0xF0, byte_count=2, busy falls after cs_n rises.
- Overrun: send 0x11 then 0x22 with no ack -> byte_data stays 0x11, overrun=1, byte_count=2; a new cs_n fall clears overrun and byte_count.
- Simultaneous: ack 0x11 in the exact cycle 0x22 completes -> byte_data=0x22, byte_valid stays 1, overrun=0.
- Abort: 5 bits then cs_n high -> abort_err one-cycle pulse, byte_valid unchanged; next frame 0x81 received correctly (partial bits flushed).
- Async reset asserted after 4 bits of 0xFF, released, then full frame 0x0F -> all outputs 0 during reset, then byte_data=0x0F, byte_count=1.

Source files
------------

// File: rtl/spi_rx_frame_ctrl.sv
// rtl/spi_rx_frame_ctrl.sv - SPI slave receive sequencer with pin sync, word assembly and valid/ack holding register
module spi_rx_frame_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              cs_n,
    input  logic              mosi,
    input  logic              byte_ack,
    output logic [DATA_W-1:0] byte_data,
    output logic [3:0]        data1,
    output logic [3:0]        data2,
    output logic              byte_valid,
    output logic              busy,
    output logic              overrun,
    output logic              abort_err,
    output logic [7:0]        byte_count
);

    localparam int              CW       = $clog2(DATA_W);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
    localparam logic [0:0]      S_IDLE   = 1'b0;
    localparam logic [0:0]      S_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic [0:0]             state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      byte_data_q, byte_data_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   abort_q, abort_d;
    logic [7:0]             count_q, count_d;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, cs_fall, cs_rise;
    logic word_done, frame_start;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;

    // An sck edge landing with cs_n rising is shifted first, so the abort test sees the updated count.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_done   = 1'b0;
        frame_start = 1'b0;
        abort_d     = 1'b0;
        if (state_q == S_IDLE) begin
            if (cs_fall) begin
                state_d     = S_ACTIVE;
                bit_cnt_d   = '0;
                frame_start = 1'b1;
            end
        end else begin
            if (sck_rise) begin
                shift_d = {shift_q[DATA_W-2:0], mosi_s};
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    word_done = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (cs_rise) begin
                state_d   = S_IDLE;
                abort_d   = (bit_cnt_d != '0);
                bit_cnt_d = '0;
            end
        end
    end

    always_comb begin
        byte_data_d  = byte_data_q;
        byte_valid_d = byte_valid_q;
        overrun_d    = overrun_q;
        count_d      = count_q;
        if (frame_start) begin
            overrun_d = 1'b0;
            count_d   = '0;
        end
        if (word_done) begin
            if (count_q != 8'hFF) begin
                count_d = count_q + 8'd1;
            end
            // A same-cycle ack frees the holding register, so the new word is taken instead of dropped.
            if (!byte_valid_q || byte_ack) begin
                byte_data_d  = shift_d;
                byte_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (byte_valid_q && byte_ack) begin
            byte_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_sync_q   <= '0;
            cs_sync_q    <= '0;
            mosi_sync_q  <= '0;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            abort_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            sck_sync_q   <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q  <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            overrun_q    <= overrun_d;
            abort_q      <= abort_d;
            count_q      <= count_d;
        end
    end

    logic [7:0] byte8;
    generate
        if (DATA_W >= 8) begin : g_wide
            assign byte8 = byte_data_q[7:0];
        end else begin : g_narrow
            assign byte8 = {{(8-DATA_W){1'b0}}, byte_data_q};
        end
    endgenerate

    assign byte_data  = byte_data_q;
    assign data1      = byte8[3:0];
    assign data2      = byte8[7:4];
    assign byte_valid = byte_valid_q;
    assign busy       = (state_q == S_ACTIVE);
    assign overrun    = overrun_q;
    assign abort_err  = abort_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_spi_rx_frame_ctrl.sv
// tb/tb_spi_rx_frame_ctrl.sv - scoreboard bench for spi_rx_frame_ctrl
module tb_spi_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst, sck, cs_n, mosi, byte_ack;
    logic [7:0] byte_data;
    logic [3:0] data1, data2;
    logic       byte_valid, busy, overrun, abort_err;
    logic [7:0] byte_count;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ack   = 1'b0;

    spi_rx_frame_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sck       (sck),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .byte_ack  (byte_ack),
        .byte_data (byte_data),
        .data1     (data1),
        .data2     (data2),
        .byte_valid(byte_valid),
        .busy      (busy),
        .overrun   (overrun),
        .abort_err (abort_err),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // A new word is visible when valid rises, or stays high right after an acked cycle.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
            prev_ack   = 1'b0;
        end else begin
            if (byte_valid && (!prev_valid || prev_ack)) begin
                if (exp_q.size() == 0) begin
                    check("sb_depth", 0, 1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("byte_data", byte_data, e);
                    check("data1", data1, e[3:0]);
                    check("data2", data2, e[7:4]);
                end
            end
            prev_valid = byte_valid;
            prev_ack   = byte_ack;
        end
    end

    task automatic cs_fall();
        cs_n = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_rise();
        cs_n = 1'b1;
        repeat (4) tick();
    endtask

    // mode 0: no ack, 1: ack 3 cycles after valid, 2: ack in the completion cycle
    task automatic send_bits(input logic [7:0] b, input int nbits, input int mode, input bit exp_load);
        if (exp_load) exp_q.push_back(b);
        for (int i = 7; i >= 8 - nbits; i--) begin
            sck  = 1'b0;
            mosi = b[i];
            repeat (4) tick();
            sck = 1'b1;
            if (i == 8 - nbits && mode == 2) begin
                tick();
                tick();
                byte_ack = 1'b1;
                tick();
                byte_ack = 1'b0;
            end else if (i == 8 - nbits && mode == 1) begin
                for (int k = 0; k < 40 && !byte_valid; k++) tick();
                check("valid_seen", byte_valid, 1);
                repeat (3) tick();
                byte_ack = 1'b1;
                @(negedge clk);
                check("valid_during_ack", byte_valid, 1);
                tick();
                byte_ack = 1'b0;
                @(negedge clk);
                check("valid_after_ack", byte_valid, 0);
            end
            repeat (4) tick();
        end
        sck = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        rst = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0; byte_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", byte_data, 0);
        check("rst_valid", byte_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_abort", abort_err, 0);
        check("rst_count", byte_count, 0);
        tick();
        rst = 1'b1;
        repeat (4) tick();

        // single word
        cs_fall();
        check("busy_single", busy, 1);
        send_bits(8'hA5, 8, 1, 1'b1);
        check("count_single", byte_count, 1);
        check("ovr_single", overrun, 0);
        cs_rise();
        check("idle_single", busy, 0);

        // back-to-back frame
        cs_fall();
        send_bits(8'h3C, 8, 1, 1'b1);
        send_bits(8'hF0, 8, 1, 1'b1);
        check("count_b2b", byte_count, 2);
        check("busy_b2b", busy, 1);
        cs_rise();
        check("idle_b2b", busy, 0);

        // overrun
        cs_fall();
        send_bits(8'h11, 8, 0, 1'b1);
        send_bits(8'h22, 8, 0, 1'b0);
        check("ovr_data", byte_data, 8'h11);
        check("ovr_valid", byte_valid, 1);
        check("ovr_flag", overrun, 1);
        check("ovr_count", byte_count, 2);
        cs_rise();
        check("ovr_sticky", overrun, 1);
        cs_fall();
        check("ovr_cleared", overrun, 0);
        check("count_cleared", byte_count, 0);

        // ack coincident with completion
        send_bits(8'h22, 8, 2, 1'b1);
        check("sim_data", byte_data, 8'h22);
        check("sim_valid", byte_valid, 1);
        check("sim_ovr", overrun, 0);
        byte_ack = 1'b1;
        tick();
        byte_ack = 1'b0;
        tick();
        cs_rise();
        check("sim_valid_clr", byte_valid, 0);

        // mid-word abort
        cs_fall();
        send_bits(8'hD8, 5, 0, 1'b0);
        cs_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (abort_err) pulses++;
        end
        check("abort_pulses", pulses, 1);
        check("abort_valid", byte_valid, 0);
        check("abort_idle", busy, 0);
        tick();
        cs_fall();
        send_bits(8'h81, 8, 1, 1'b1);
        check("count_after_abort", byte_count, 1);
        check("no_abort_clean", abort_err, 0);
        cs_rise();

        // async reset mid-word
        cs_fall();
        send_bits(8'hFF, 4, 0, 1'b0);
        rst = 1'b0;
        #1;
        check("arst_data", byte_data, 0);
        check("arst_busy", busy, 0);
        check("arst_count", byte_count, 0);
        check("arst_valid", byte_valid, 0);
        cs_n = 1'b1;
        sck  = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (4) tick();
        check("arst_idle", busy, 0);
        cs_fall();
        send_bits(8'h0F, 8, 1, 1'b1);
        check("arst_count_after", byte_count, 1);
        check("arst_data_after", byte_data, 8'h0F);
        cs_rise();

        check("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1);
    end

endmodule
